// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Access-size encoding and byte-lane helpers for rv_unified_mem.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } mem_size_e;

  function automatic logic [3:0] byte_en(input mem_size_e sz, input logic [1:0] lsb);
    case (sz)
      SZ_B:    return 4'b0001 << lsb;
      SZ_H:    return lsb[1] ? 4'b1100 : 4'b0011;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Illegal size is treated as a misalignment so one flag covers both.
  function automatic logic misaligned(input mem_size_e sz, input logic [1:0] lsb);
    case (sz)
      SZ_H:    return lsb[0];
      SZ_W:    return |lsb;
      SZ_ILL:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input mem_size_e sz, input logic [31:0] d);
    case (sz)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// ============================================================================
// Module : mem_load_align
// Brief  : Lane select and sign/zero extension of a registered load word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lsb,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_lsb, 3'b000} +: 8];
  assign w_half = i_lsb[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = 32'h0;
    case (mem_size_e'(i_size))
      SZ_B:    o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_H:    o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      SZ_W:    o_data = i_word;
      default: o_data = 32'h0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv_unified_mem.sv
// ============================================================================
// Module : rv_unified_mem
// Brief  : Single-port synchronous unified I/D memory with starvation-bounded
//          data-priority arbitration between fetch and load/store ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv_unified_mem
  import mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 131072,
  parameter string INIT_FILE   = "",
  parameter int    STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int c_STW = $clog2(STARVE_MAX + 1);
  localparam logic [c_STW-1:0] c_STARVE_SAT = c_STW'(STARVE_MAX);

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [31:0]      r_rword;
  logic [c_STW-1:0] r_starve;
  logic             r_if_rvalid;
  logic             r_d_rvalid;
  logic             r_d_err;
  logic             r_d_zero;
  logic [1:0]       r_lsb;
  logic [1:0]       r_size;
  logic             r_uns;
  logic [31:0]      r_if_last;
  logic [31:0]      r_d_last;

  logic             w_d_ready;
  logic             w_if_ready;
  logic             w_range_err;
  logic             w_d_err;
  logic             w_we;
  logic [3:0]       w_be;
  logic [31:0]      w_wlanes;
  logic [AW-1:0]    w_idx;
  logic [31:0]      w_load_data;
  logic             w_unused_addr;
  mem_size_e        w_size;

  assign w_d_ready  = d_req & ~rst & ~(if_req & (r_starve == c_STARVE_SAT));
  assign w_if_ready = if_req & ~rst & ~w_d_ready;
  assign d_ready    = w_d_ready;
  assign if_ready   = w_if_ready;

  assign w_size      = mem_size_e'(d_size);
  assign w_range_err = {2'b00, d_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign w_d_err     = misaligned(w_size, d_addr[1:0]) | w_range_err;
  assign w_we        = w_d_ready & d_we & ~w_d_err;
  assign w_be        = byte_en(w_size, d_addr[1:0]);
  assign w_wlanes    = store_lanes(w_size, d_wdata);
  assign w_idx       = w_d_ready ? d_addr[AW+1:2] : if_addr[AW+1:2];

  // Fetch addresses wrap, so their upper bits are intentionally dropped.
  assign w_unused_addr = &{1'b0, if_addr[1:0], if_addr[31:AW+2]};

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_we && w_be[b]) begin
        r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
    if (w_d_ready || w_if_ready) begin
      r_rword <= r_mem[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve    <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_zero    <= 1'b0;
      r_lsb       <= 2'b00;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
      r_if_last   <= 32'h0;
      r_d_last    <= 32'h0;
    end else begin
      if (if_req && !w_if_ready) begin
        if (r_starve != c_STARVE_SAT) begin
          r_starve <= r_starve + 1'b1;
        end
      end else begin
        r_starve <= '0;
      end
      r_if_rvalid <= w_if_ready;
      r_d_rvalid  <= w_d_ready;
      r_d_err     <= w_d_ready & w_d_err;
      if (w_d_ready) begin
        r_d_zero <= d_we | w_d_err;
        r_lsb    <= d_addr[1:0];
        r_size   <= d_size;
        r_uns    <= d_unsigned;
      end
      // Shadow copies let the shared read register serve both ports while
      // each port's data output holds between its own responses.
      r_if_last <= if_rdata;
      r_d_last  <= d_rdata;
    end
  end

  mem_load_align u_align (
    .i_word     (r_rword),
    .i_lsb      (r_lsb),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_load_data)
  );

  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rvalid ? r_rword : r_if_last;
  assign d_rvalid  = r_d_rvalid;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rvalid ? (r_d_zero ? 32'h0 : w_load_data) : r_d_last;

endmodule

`default_nettype wire

// File: tb/tb_rv_unified_mem.sv
// ============================================================================
// Module : tb_rv_unified_mem
// Brief  : Self-checking bench for rv_unified_mem with a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv_unified_mem;

  localparam int DEPTH  = 1024;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_ready, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [1:0]  d_size = 2'b10;
  logic        d_unsigned = 1'b0;
  logic        d_ready, d_rvalid, d_err;
  logic [31:0] d_rdata;

  rv_unified_mem #(
    .DEPTH_WORDS (DEPTH),
    .INIT_FILE   (""),
    .STARVE_MAX  (STARVE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ready   (if_ready),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_size     (d_size),
    .d_unsigned (d_unsigned),
    .d_ready    (d_ready),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_err      (d_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  int          denials = 0;
  logic        x_if_rv = 1'b0, x_d_rv = 1'b0, x_d_err = 1'b0;
  logic [31:0] x_if_rd = 32'h0, x_d_rd = 32'h0;
  bit          armed = 1'b0;

  function automatic logic mdl_err(input logic [31:0] a, input int sz);
    return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0)
           || ((a >> 2) >= DEPTH);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [31:0] a,
                                           input int sz, input logic u);
    logic [31:0] v;
    if (sz == 2) return w;
    if (sz == 0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic model_step();
    logic        e_d, e_f;
    int          sz, sh;
    logic [31:0] mask;
    int          idx;
    if (rst) begin
      if (armed) begin
        chk("d_ready_rst", d_ready, 1'b0);
        chk("if_ready_rst", if_ready, 1'b0);
      end
      armed   = 1'b1;
      denials = 0;
      x_if_rv = 1'b0; x_d_rv = 1'b0; x_d_err = 1'b0;
      x_if_rd = 32'h0; x_d_rd = 32'h0;
      return;
    end
    e_d = d_req && !(if_req && denials == STARVE);
    e_f = if_req && !e_d;
    if (armed) begin
      chk("d_ready", d_ready, e_d);
      chk("if_ready", if_ready, e_f);
    end
    if (if_req && !e_f) denials = (denials < STARVE) ? denials + 1 : STARVE;
    else                denials = 0;
    x_if_rv = e_f;
    if (e_f) x_if_rd = m_mem[(if_addr >> 2) % DEPTH];
    x_d_rv  = e_d;
    x_d_err = 1'b0;
    if (e_d) begin
      sz  = int'(d_size);
      idx = int'(d_addr >> 2);
      if (mdl_err(d_addr, sz)) begin
        x_d_err = 1'b1;
        x_d_rd  = 32'h0;
      end else if (d_we) begin
        if (sz == 0)      begin sh = 8 * int'(d_addr % 4);        mask = 32'hFF << sh;   end
        else if (sz == 1) begin sh = 16 * int'((d_addr / 2) % 2); mask = 32'hFFFF << sh; end
        else              begin sh = 0;                           mask = 32'hFFFF_FFFF;  end
        m_mem[idx] = (m_mem[idx] & ~mask) | ((d_wdata << sh) & mask);
        x_d_rd = 32'h0;
      end else begin
        x_d_rd = mdl_load(m_mem[idx], d_addr, sz, d_unsigned);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("if_rvalid", if_rvalid, x_if_rv);
        chk("if_rdata", if_rdata, x_if_rd);
        chk("d_rvalid", d_rvalid, x_d_rv);
        chk("d_err", d_err, x_d_err);
        chk("d_rdata", d_rdata, x_d_rd);
      end
      #4;
      model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns,
                          output logic [31:0] rd, output logic er);
    bit got;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; d_size = sz; d_unsigned = uns;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk); #4;
      got = d_ready;
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL d_ready_timeout: addr %h never granted", addr);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    chk("d_rvalid_after_grant", d_rvalid, 1'b1);
    rd = d_rdata;
    er = d_err;
  endtask

  task automatic f_access(input logic [31:0] addr, output logic [31:0] rd);
    bit got;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = addr;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk); #4;
      got = if_ready;
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL if_ready_timeout: addr %h never granted", addr);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("if_rvalid_after_grant", if_rvalid, 1'b1);
    rd = if_rdata;
  endtask

  task automatic rand_fetch(input int n);
    logic g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #4;
      g = if_ready;
      @(posedge clk); #1;
      if (!if_req || g) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = $urandom;
      end
    end
    if_req = 1'b0;
  endtask

  task automatic rand_data(input int n);
    logic g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #4;
      g = d_ready;
      @(posedge clk); #1;
      if (!d_req || g) begin
        d_req      = ($urandom_range(0, 2) != 0);
        d_we       = $urandom_range(0, 1);
        d_size     = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        d_addr     = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH*4 - 1));
        if ($urandom_range(0, 3) != 0) begin
          if (d_size == 2'b01) d_addr[0] = 1'b0;
          if (d_size == 2'b10) d_addr[1:0] = 2'b00;
        end
        d_wdata    = $urandom;
        d_unsigned = $urandom_range(0, 1);
      end
    end
    d_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    logic [9:0]  pat;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) d_access(1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0, rd, er);

    d_access(1'b1, 32'h40, 32'h8000_F0A5, 2'b10, 1'b0, rd, er);
    chk("sw_resp_rdata", rd, 32'h0);
    chk("sw_resp_err", er, 1'b0);
    d_access(1'b0, 32'h40, 32'h0, 2'b00, 1'b0, rd, er);
    chk("lb_0x40", rd, 32'hFFFF_FFA5);
    d_access(1'b0, 32'h43, 32'h0, 2'b00, 1'b1, rd, er);
    chk("lbu_0x43", rd, 32'h0000_0080);
    d_access(1'b0, 32'h42, 32'h0, 2'b01, 1'b0, rd, er);
    chk("lh_0x42", rd, 32'hFFFF_8000);

    d_access(1'b1, 32'h100, 32'h1122_3344, 2'b10, 1'b0, rd, er);
    d_access(1'b1, 32'h101, 32'h0000_00AB, 2'b00, 1'b0, rd, er);
    d_access(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, rd, er);
    chk("lw_after_sb", rd, 32'h1122_AB44);
    d_access(1'b1, 32'h102, 32'h0000_BEEF, 2'b01, 1'b0, rd, er);
    d_access(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, rd, er);
    chk("lw_after_sh", rd, 32'hBEEF_AB44);

    d_access(1'b0, 32'h102, 32'h0, 2'b10, 1'b0, rd, er);
    chk("lw_misaligned_err", er, 1'b1);
    chk("lw_misaligned_rdata", rd, 32'h0);
    d_access(1'b1, 32'h101, 32'h0000_DEAD, 2'b01, 1'b0, rd, er);
    chk("sh_misaligned_err", er, 1'b1);
    d_access(1'b1, 32'h100, 32'h5555_5555, 2'b11, 1'b0, rd, er);
    chk("size11_err", er, 1'b1);
    chk("size11_rdata", rd, 32'h0);
    d_access(1'b0, 32'(DEPTH * 4), 32'h0, 2'b10, 1'b0, rd, er);
    chk("range_err", er, 1'b1);
    d_access(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, rd, er);
    chk("mem_unchanged", rd, 32'hBEEF_AB44);

    d_access(1'b1, 32'h200, 32'h0000_0013, 2'b10, 1'b0, rd, er);
    f_access(32'h200, rd);
    chk("fetch_after_sw", rd, 32'h0000_0013);
    f_access(32'h200 + 32'(DEPTH * 4), rd);
    chk("fetch_wrap", rd, 32'h0000_0013);

    // Reset arriving after a load is already being granted.
    d_access(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, rd, er);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_size = 2'b10; d_unsigned = 1'b0;
    @(negedge clk);
    chk("d_ready_pre_rst", d_ready, 1'b1);
    #1 rst = 1'b1; if_req = 1'b1; if_addr = 32'h0;
    #1;
    chk("d_ready_in_rst", d_ready, 1'b0);
    chk("if_ready_in_rst", if_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; d_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("post_rst_d_rvalid", d_rvalid, 1'b0);
    chk("post_rst_if_rvalid", if_rvalid, 1'b0);
    chk("post_rst_d_err", d_err, 1'b0);
    chk("post_rst_d_rdata", d_rdata, 32'h0);
    chk("post_rst_if_rdata", if_rdata, 32'h0);

    // Both ports requesting continuously.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_size = 2'b10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #4;
      pat[9 - i] = d_ready;
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    chk("grant_pattern_DDDDFDDDDF", {22'h0, pat}, 32'b11_1101_1110);

    fork
      rand_fetch(1500);
      rand_data(1500);
    join
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
